// File: rtl/clk_enable_gen.sv
// Clock-enable generator.
// Produces one-cycle strobes every D clocks, with a programmable start phase.
// Runs either freely or for a fixed burst of L strobes. Configuration is
// captured only when a valid sync is accepted. A rejected sync raises a
// one-cycle error pulse and leaves the running sequence untouched.
module clk_enable_gen #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_enable,
    input  logic               i_sync,
    input  logic               i_mode,
    input  logic [CNT_W-1:0]   i_divisor,
    input  logic [CNT_W-1:0]   i_phase,
    input  logic [BURST_W-1:0] i_burst_len,
    output logic               o_strobe,
    output logic               o_busy,
    output logic [BURST_W-1:0] o_strobe_count,
    output logic               o_cfg_err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RUN_FREE  = 2'd1;
    localparam logic [1:0] RUN_BURST = 2'd2;

    localparam logic [BURST_W-1:0] COUNT_MAX = '1;

    logic [1:0]         state_reg,   state_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic [CNT_W-1:0]   div_reg,     div_next;
    logic [CNT_W-1:0]   phase_reg,   phase_next;
    logic               mode_reg,    mode_next;
    logic [BURST_W-1:0] len_reg,     len_next;
    logic               strobe_reg,  strobe_next;
    logic [BURST_W-1:0] count_reg,   count_next;
    logic               cfg_err_reg, cfg_err_next;

    logic               sync_valid;
    logic [CNT_W-1:0]   div_in_m1;
    logic [CNT_W-1:0]   phase_clamp;
    logic [CNT_W-1:0]   div_m1;
    logic               at_wrap;
    logic [BURST_W-1:0] count_inc;

    // The phase shadow holds the accepted offset; nothing downstream reads it.
    logic unused_phase;
    assign unused_phase = ^phase_reg;

    // A sync is acceptable only with a nonzero divisor and, in burst mode, a
    // nonzero burst length. The start offset is clamped to D-1 so the counter
    // never starts outside its range.
    assign sync_valid  = (i_divisor != '0) && !(i_mode && (i_burst_len == '0));
    assign div_in_m1   = i_divisor - CNT_W'(1);
    assign phase_clamp = (i_phase > div_in_m1) ? div_in_m1 : i_phase;
    assign div_m1      = div_reg - CNT_W'(1);
    assign at_wrap     = (cnt_reg == div_m1);
    assign count_inc   = (count_reg == COUNT_MAX) ? count_reg : count_reg + BURST_W'(1);

    // Next-state logic, in priority order: enable low, accepted sync, then wrap.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        div_next     = div_reg;
        phase_next   = phase_reg;
        mode_next    = mode_reg;
        len_next     = len_reg;
        strobe_next  = 1'b0;
        count_next   = count_reg;
        cfg_err_next = 1'b0;

        if (!i_enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (i_sync && sync_valid) begin
            div_next   = i_divisor;
            phase_next = i_phase;
            mode_next  = i_mode;
            len_next   = i_burst_len;
            cnt_next   = phase_clamp;
            count_next = '0;
            state_next = i_mode ? RUN_BURST : RUN_FREE;
        end else begin
            cfg_err_next = i_sync;
            if (state_reg == IDLE) begin
                cnt_next = '0;
            end else if (at_wrap) begin
                cnt_next    = '0;
                strobe_next = 1'b1;
                count_next  = count_inc;
                if (mode_reg && (count_inc == len_reg)) begin
                    state_next = IDLE;
                end
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    // State and output registers, cleared immediately by the async reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            div_reg     <= '0;
            phase_reg   <= '0;
            mode_reg    <= 1'b0;
            len_reg     <= '0;
            strobe_reg  <= 1'b0;
            count_reg   <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            div_reg     <= div_next;
            phase_reg   <= phase_next;
            mode_reg    <= mode_next;
            len_reg     <= len_next;
            strobe_reg  <= strobe_next;
            count_reg   <= count_next;
            cfg_err_reg <= cfg_err_next;
        end
    end

    assign o_strobe       = strobe_reg;
    assign o_busy         = (state_reg != IDLE);
    assign o_strobe_count = count_reg;
    assign o_cfg_err      = cfg_err_reg;

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter CNT_W, default 16: width of the divisor, phase and cycle counter.
REQ-002 Parameter BURST_W, default 8: width of the burst length and strobe count.
REQ-003 i_clk  in  1  clock; all state changes on its rising edge.
REQ-004 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 i_enable  in  1  level; low forces IDLE.
REQ-006 i_sync  in  1  single-cycle pulse; latches config and realigns the phase.
REQ-007 i_mode  in  1  0 = free-run, 1 = burst.
REQ-008 i_divisor  in  CNT_W  strobe period D in clock cycles; 0 is invalid.
REQ-009 i_phase  in  CNT_W  start offset P, applied at sync.
REQ-010 i_burst_len  in  BURST_W  strobes per burst L; 0 is invalid in burst mode.
REQ-011 o_strobe  out  1  registered enable pulse, one cycle wide.
REQ-012 o_busy  out  1  high whenever state is not IDLE.
REQ-013 o_strobe_count  out  BURST_W  strobes issued since the last accepted sync.
REQ-014 o_cfg_err  out  1  registered one-cycle pulse flagging a rejected sync.

Function
REQ-015 The block SHALL use three states: IDLE, RUN_FREE and RUN_BURST.
REQ-016 Config SHALL be sampled only on an accepted sync:
- i_divisor, i_phase, i_mode and i_burst_len latch into shadow registers.
- Changes to these inputs between syncs SHALL have no effect.
REQ-017 A sync SHALL be accepted when all of the following hold:
- i_enable=1
- i_divisor!=0
- not (i_mode=1 and i_burst_len=0)
REQ-018 A sync with i_enable=1 and invalid config SHALL be rejected:
- o_cfg_err=1 in the next cycle.
- State, counter, count and shadow registers unchanged.
REQ-019 On an accepted sync, on the same edge:
- Counter loads P' = min(P, D-1).
- o_strobe_count clears to 0.
- o_strobe=0.
- State goes to RUN_FREE (mode 0) or RUN_BURST (mode 1).
- This applies from IDLE and from either RUN state (re-sync restarts a burst).
REQ-020 In a RUN state, when the counter is below D-1, the counter SHALL increment and o_strobe=0.
REQ-021 In a RUN state, when the counter equals D-1:
- Counter wraps to 0.
- o_strobe=1 next cycle.
- Consequence: the first strobe comes D-P' cycles after the sync edge, then one every D cycles.
REQ-022 D=1 SHALL give o_strobe=1 on every cycle after the sync edge.
REQ-023 Each strobe SHALL increment o_strobe_count, saturating at 2^BURST_W-1 in free-run.
REQ-024 In RUN_BURST, the strobe that makes the count equal L SHALL also move the state to IDLE on the same edge:
- o_strobe=1 and o_busy=0 in the same cycle.
- o_strobe_count holds L afterwards.
REQ-025 In IDLE:
- Counter held at 0 and o_strobe=0.
- o_strobe_count holds its last value.
REQ-026 i_enable=0 in any state SHALL, on the next edge:
- Force IDLE.
- Set counter to 0 and o_strobe=0.
- Ignore any concurrent sync; no o_cfg_err.
REQ-027 Priority, highest first: i_enable=0, then accepted sync, then wrap/strobe; a sync coinciding with wrap suppresses that strobe.
REQ-028 Counter and comparison arithmetic SHALL be unsigned CNT_W bits; the counter never exceeds D-1.

Reset
REQ-029 Asserting i_reset_n low SHALL immediately, regardless of clock:
- State IDLE.
- Counter 0 and shadow registers 0.
- o_strobe=0, o_busy=0, o_strobe_count=0, o_cfg_err=0.
REQ-030 Reset mid-run SHALL abort any burst with no further strobes.
REQ-031 After reset release, the block SHALL remain IDLE until an accepted sync.

Verification
REQ-032 Free-run, D=5, P=0, sync at edge 0 -> o_strobe high in cycles 5, 10, 15, ...; o_busy=1 from cycle 1.
REQ-033 Phase, D=5, P=3 -> first strobe at cycle 2, then cycles 7, 12; P=9 clamps to 4 -> first strobe at cycle 1.
REQ-034 Burst, D=4, L=3 -> strobes at cycles 4, 8, 12; o_busy=0 from cycle 12; o_strobe_count=3; no strobe at 16.
REQ-035 Invalid config: sync with D=0, or mode=1 with L=0 -> o_cfg_err one cycle, o_busy unchanged; the running sequence continues undisturbed.
REQ-036 Re-sync and wrap collide: D=5 running, sync on the wrap cycle -> that strobe suppressed, count=0, next strobe 5 cycles later.
REQ-037 Enable/reset mid-burst: i_enable low -> IDLE next edge, no strobe; async reset mid-burst -> all outputs 0 immediately.
